serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
//   LSB first, using a single full-subtractor cell and a registered borrow.
//   It is the inverse datapath of the small ripple adders in the arithmetic
//   library, and it serves as a low-area SUB unit with a start/done handshake.
//   Flags: unsigned borrow (a < b) and signed overflow.
// PARAMETERS
//   WIDTH  8  operand and result width in bits (>= 2)
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous, active-low reset
//   start     in   1      request; sampled only while busy == 0
//   a         in   WIDTH  minuend; latched on accepted start
//   b         in   WIDTH  subtrahend; latched on accepted start
//   busy      out  1      high while bits are being processed (RUN)
//   done      out  1      single-cycle pulse; result valid
//   diff      out  WIDTH  a - b mod 2^WIDTH; held until next done
//   borrow    out  1      1 iff unsigned a < b; held with diff
//   overflow  out  1      signed overflow of a - b; held with diff
// BEHAVIOUR
//   Reset (rst_n = 0, async): state = IDLE, busy = 0, done = 0, diff = 0,
//     borrow = 0, overflow = 0, bit counter = 0, internal borrow = 0.
//   FSM states: IDLE, RUN, DONE.
//     IDLE/DONE: start = 1 at edge t -> latch a, b into shift regs; clear the
//       internal borrow; counter = 0; go to RUN. Otherwise IDLE.
//     RUN: each edge, compute d_i = a_i ^ b_i ^ br and
//       br' = (~a_i & b_i) | (~(a_i ^ b_i) & br); shift d_i into the result
//       shift reg (MSB-in, so after WIDTH shifts bit 0 is aligned); shift the
//       operands right; counter++. On the edge where counter == WIDTH-1, go to
//       DONE, load diff <= the full result, borrow <= final br',
//       overflow <= (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]), where a and b
//       are the latched operands.
//     DONE: lasts exactly one cycle; done = 1; then IDLE unless start accepted.
//   Latency: start accepted at edge t -> done high in the cycle after edge
//     t+WIDTH (WIDTH RUN cycles); back-to-back throughput = 1 op / (WIDTH+1).
//   busy = (state == RUN); done = (state == DONE); both registered.
//   start while busy == 1 is ignored (no queueing), and a/b changes during RUN
//     have no effect.
//   diff/borrow/overflow change only on the edge entering DONE; they stay
//     stable in IDLE and during the next RUN.
//   A reset mid-RUN aborts the operation, and every output goes to its reset
//     value immediately (async). The first start after rst_n rises is
//     processed normally.
//   The counter is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
// TESTING
//   1 WIDTH=8, a=8'h05, b=8'h03, start pulse -> busy for 8 cycles, done in
//     cycle 9, diff=8'h02, borrow=0, overflow=0.
//   2 a=8'h03, b=8'h05 -> diff=8'hFE, borrow=1, overflow=0; a=8'h80,
//     b=8'h01 -> diff=8'h7F, borrow=0, overflow=1.
//   3 Edge values: 8'h00-8'h00 -> 8'h00/0/0; 8'hFF-8'hFF -> 8'h00/0/0;
//     8'h00-8'hFF -> 8'h01, borrow=1, overflow=0; 8'h7F-8'hFF -> 8'h80,
//     borrow=1, overflow=1.
//   4 Second start and changed a/b during RUN -> ignored; result is from the
//     first operands; diff holds the old value until done.
//   5 start held high through DONE -> new op accepted the same edge DONE
//     exits; two done pulses 9 cycles apart.
//   6 rst_n low at the 4th RUN cycle -> busy/done/diff/flags are 0
//     immediately; a fresh 8'h0A-8'h04 after release -> diff=8'h06.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Start/done handshake; result and flags are held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  // Full-subtractor cell on the current LSBs of the operand shifters
  assign a_bit = a_q[0];
  assign b_bit = b_q[0];
  assign d_bit = a_bit ^ b_bit ^ br_q;
  assign br_d  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  assign res_d = {d_bit, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_q     <= a;
            b_q     <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          br_q  <= br_d;
          if (cnt_q == LAST) begin
            // a_bit/b_bit are the operand sign bits on the final step
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= res_d;
            borrow_q <= br_d;
            ovf_q    <= (a_bit != b_bit) && (d_bit != a_bit);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;

endmodule
